// File: rtl/uni_stream_decoder.sv
// Unary-to-binary stream decoder: counts 1s over a 2^LOG_LEN-cycle window, returns result via valid/ready.
// Optional macro UNI_DEC_BIPOLAR_EN selects two's-complement (bipolar) output instead of unsigned.
module uni_stream_decoder #(
  parameter int LOG_LEN = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               iStream,
  input  logic               start,
  output logic               busy,
  output logic               oValid,
  input  logic               oReady,
  output logic [LOG_LEN-1:0] oData
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [LOG_LEN:0]   count;
  logic [LOG_LEN-1:0] bitCnt;
  logic [LOG_LEN:0]   nxtCount;

  localparam int HALF = 1 << (LOG_LEN - 1);

  function automatic logic [LOG_LEN-1:0] satOut(input logic [LOG_LEN:0] c);
`ifdef UNI_DEC_BIPOLAR_EN
    logic signed [LOG_LEN+1:0] d;
    // c >= 0 so d never drops below -HALF; only the upper bound can overflow
    d = signed'({1'b0, c}) - signed'((LOG_LEN+2)'(HALF));
    if (d > signed'((LOG_LEN+2)'(HALF - 1)))
      return (LOG_LEN)'(HALF - 1);
    else
      return d[LOG_LEN-1:0];
`else
    if (c[LOG_LEN])
      return '1;
    else
      return c[LOG_LEN-1:0];
`endif
  endfunction

  always_comb begin
    nxtCount = count + (LOG_LEN+1)'(iStream);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      oValid <= 1'b0;
      oData  <= '0;
      count  <= '0;
      bitCnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            busy   <= 1'b1;
            count  <= (LOG_LEN+1)'(iStream);
            bitCnt <= (LOG_LEN)'(1);
          end
        end
        RUN: begin
          count  <= nxtCount;
          bitCnt <= bitCnt + (LOG_LEN)'(1);
          if (bitCnt == '1) begin
            state  <= DONE;
            busy   <= 1'b0;
            oValid <= 1'b1;
            oData  <= satOut(nxtCount);
          end
        end
        DONE: begin
          if (oReady) begin
            oValid <= 1'b0;
            // accept-and-restart in one cycle: this cycle's iStream is bit 0 of the new window
            if (start) begin
              state  <= RUN;
              busy   <= 1'b1;
              count  <= (LOG_LEN+1)'(iStream);
              bitCnt <= (LOG_LEN)'(1);
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
